// File: rtl/dmem_responder.sv
// Data-memory responder: word-wide load/store with byte enables, a fixed
// number of wait states, and a single-cycle ack/err response per request.
module dmem_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          WAIT_CYC = 2,
  parameter logic [31:0] BASE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int          CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic             ack_reg;
  logic             err_reg;

  logic              accept;
  logic              resp_edge;
  logic [31:0]       offset;
  logic [31:0]       word_off;
  logic              req_err;
  logic [ADDR_W-1:0] idx;

  assign accept    = req && (state_reg == S_IDLE);
  assign resp_edge = (state_reg == S_BUSY) && (cnt_reg == '0);

  // Error decode works on the latched address so late input changes are ignored.
  assign offset   = addr_reg - BASE;
  assign word_off = offset >> 2;
  assign req_err  = (addr_reg[1:0] != 2'b00) || (addr_reg < BASE) || (word_off >= DEPTH_W);
  assign idx      = word_off[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ack_reg <= resp_edge;
      err_reg <= resp_edge && req_err;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            be_reg    <= be;
            cnt_reg   <= CNT_W'(WAIT_CYC);
            state_reg <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One RAM per byte lane keeps byte-enable writes a plain single-port inference.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (!rst && resp_edge && we_reg && !req_err && be_reg[gi]) begin
          lane_mem[idx] <= wdata_reg[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_byte_reg <= 8'h00;
        end else if (resp_edge) begin
          rd_byte_reg <= (!we_reg && !req_err) ? lane_mem[idx] : 8'h00;
        end
      end

      assign rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  assign ready = (state_reg == S_IDLE);
  assign ack   = ack_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner sequences,
// a WAIT_CYC=0 throughput check and randomized traffic against a word model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, ack, err;
  logic [31:0] rdata;

  logic        req0;
  logic        ready0, ack0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(2), .BASE(32'h0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(0), .BASE(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(1'b1), .addr(32'h40), .wdata(32'h0), .be(4'h0),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic calc_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 1024);
  endfunction

  // One full transaction: accept, wait for the single ack, check latency and response.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic e_err, input logic [31:0] e_rd,
                        input string nm);
    int lat, low, nack;
    logic [31:0] mask;
    @(negedge clk);
    check({nm, " ready before"}, {31'b0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    lat = -1; low = 0; nack = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) break;
      low++;
      if (ack) begin
        nack++;
        if (lat < 0) lat = i;
        check({nm, " err"}, {31'b0, err}, {31'b0, e_err});
        check({nm, " rdata"}, rdata, e_rd);
      end
      @(posedge clk); #1;
    end
    check({nm, " ack latency"}, lat, 3);
    check({nm, " ack count"}, nack, 1);
    check({nm, " ready low cycles"}, low, 4);
    check({nm, " ack low in idle"}, {31'b0, ack}, 32'd0);
    check({nm, " rdata hold"}, rdata, e_rd);
    if (w && !e_err) begin
      if (!model.exists(int'(a >> 2))) model[int'(a >> 2)] = 32'h0;
      for (int l = 0; l < 4; l++) begin
        if (b[l]) begin
          mask = 32'hFF << (8 * l);
          model[int'(a >> 2)] = (model[int'(a >> 2)] & ~mask) | (d & mask);
        end
      end
    end
    $display("txn %s we=%0d addr=%h wdata=%h be=%h lat=%0d err=%0d rdata=%h",
             nm, w, a, d, b, lat, err, rdata);
  endtask

  initial begin
    int acks, last_ack, pos;
    logic [31:0] a, d;
    logic        w, e;
    int          k, sel;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        "st10_full"};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADBEEF, "ld10_a"};
    vecs[2]  = '{1'b1, 32'h10,  32'h0000AA00, 4'h2, 1'b0, 32'h0,        "st10_lane1"};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADAAEF, "ld10_b"};
    vecs[4]  = '{1'b1, 32'h13,  32'h11111111, 4'hF, 1'b1, 32'h0,        "st13_misalign"};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADAAEF, "ld10_c"};
    vecs[6]  = '{1'b0, 32'h1000, 32'h0,       4'hF, 1'b1, 32'h0,        "ld1000_range"};
    vecs[7]  = '{1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        "stffc"};
    vecs[8]  = '{1'b0, 32'hFFC, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, "ldffc"};
    vecs[9]  = '{1'b1, 32'h10,  32'h99999999, 4'h0, 1'b0, 32'h0,        "st10_be0"};
    vecs[10] = '{1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADAAEF, "ld10_d"};
    vecs[11] = '{1'b1, 32'h20,  32'h0BADF00D, 4'hF, 1'b0, 32'h0,        "st20"};
    vecs[12] = '{1'b1, 32'h22,  32'h0,        4'h0, 1'b1, 32'h0,        "st22_misalign"};

    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'b0, ready}, 32'd1);
    check("reset ack", {31'b0, ack}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].name);

    // Reset while BUSY: no ack, no write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy ready", {31'b0, ready}, 32'd1);
    check("rst_busy ack", {31'b0, ack}, 32'd0);
    @(negedge clk); rst = 1'b0;
    acks = 0;
    repeat (6) begin @(posedge clk); #1; if (ack) acks++; end
    check("rst_busy no ack", acks, 0);
    $display("txn rst_busy acks=%0d", acks);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, "ld20_after_rst_busy");

    // Reset on the edge that would enter RESP: the store must not land.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_resp ack", {31'b0, ack}, 32'd0);
    check("rst_resp ready", {31'b0, ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    $display("txn rst_resp ack=%0d", ack);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, "ld20_after_rst_resp");

    // Zero-wait build with req held: one ack every third cycle.
    @(negedge clk); req0 = 1'b1;
    acks = 0; last_ack = -10; pos = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack0) begin
        acks++;
        if (last_ack >= 0) check("wait0 ack spacing", i - last_ack, 3);
        else check("wait0 first ack", i, 2);
        last_ack = i;
        check("wait0 ready low on ack", {31'b0, ready0}, 32'd0);
        check("wait0 err", {31'b0, err0}, 32'd0);
      end
    end
    @(negedge clk); req0 = 1'b0;
    check("wait0 ack total", acks, 7);
    $display("txn wait0_stream acks=%0d", acks);

    // Random traffic against the word model.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      k = $urandom_range(0, 7);
      if (sel <= 6)      a = 32'h100 + 32'(4 * k);
      else if (sel == 7) a = 32'h100 + 32'(4 * k) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h1000 + 32'(4 * k);
      else               a = 32'hFFFF_FFFC;
      e = calc_err(a);
      w = 1'($urandom_range(0, 1));
      if (!e && !model.exists(int'(a >> 2))) w = 1'b1;
      d = $urandom;
      do_req(w, a, d, 4'($urandom_range(0, 15)), e,
             (w || e) ? 32'h0 : model[int'(a >> 2)], $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
